// File: rtl/shift_arbiter_if.sv
// Request/response bundle for the shared shifter: two valid/ready request
// channels and one valid/ready response channel.
interface shift_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_src;
    logic [3:0]  req0_shamt;
    logic [1:0]  req0_dir;

    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_src;
    logic [3:0]  req1_shamt;
    logic [1:0]  req1_dir;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zr;
    logic        rsp_id;
    logic        busy;

    modport master (
        output req0_valid, req0_src, req0_shamt, req0_dir,
        input  req0_ready,
        output req1_valid, req1_src, req1_shamt, req1_dir,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_zr, rsp_id, busy,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_src, req0_shamt, req0_dir,
        output req0_ready,
        input  req1_valid, req1_src, req1_shamt, req1_dir,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_zr, rsp_id, busy,
        input  rsp_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one 16-bit logical shifter; one operation
// in flight, operands registered before shifting, result held until taken.
module shift_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    shift_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StResp} state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] src_q, src_d;
    logic [3:0]  shamt_q, shamt_d;
    logic [1:0]  dir_q, dir_d;
    logic        id_q, id_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_zr_q, rsp_zr_d;
    logic        rsp_valid_q, rsp_valid_d;

    logic        grant;
    logic [15:0] shift_out;

    // Requester 1 wins when alone, or on a round-robin tie after requester 0 last won.
    assign grant = bus.req1_valid & (~bus.req0_valid | (RR_EN & ~last_grant_q));

    assign shift_out = (dir_q == 2'd1) ? (src_q << shamt_q) : (src_q >> shamt_q);

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        src_d          = src_q;
        shamt_d        = shamt_q;
        dir_d          = dir_q;
        id_d           = id_q;
        rsp_data_d     = rsp_data_q;
        rsp_zr_d       = rsp_zr_q;
        rsp_valid_d    = rsp_valid_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.req0_valid | bus.req1_valid) begin
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                    src_d          = grant ? bus.req1_src   : bus.req0_src;
                    shamt_d        = grant ? bus.req1_shamt : bus.req0_shamt;
                    dir_d          = grant ? bus.req1_dir   : bus.req0_dir;
                    id_d           = grant;
                    last_grant_d   = grant;
                    state_d        = StShift;
                end
            end
            StShift: begin
                rsp_data_d  = shift_out;
                rsp_zr_d    = (shift_out == 16'h0000);
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            src_q        <= 16'h0000;
            shamt_q      <= 4'h0;
            dir_q        <= 2'h0;
            id_q         <= 1'b0;
            rsp_data_q   <= 16'h0000;
            rsp_zr_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            src_q        <= src_d;
            shamt_q      <= shamt_d;
            dir_q        <= dir_d;
            id_q         <= id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_zr_q     <= rsp_zr_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zr    = rsp_zr_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: a vector table of single operations plus
// sequences for contention, response back-pressure and mid-operation reset.
module tb_shift_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_arbiter_if bus();
    shift_arbiter_if bus_fp();

    shift_arbiter #(.RR_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    shift_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp)
    );

    // The fixed-priority instance sees exactly the same stimulus.
    assign bus_fp.req0_valid = bus.req0_valid;
    assign bus_fp.req0_src   = bus.req0_src;
    assign bus_fp.req0_shamt = bus.req0_shamt;
    assign bus_fp.req0_dir   = bus.req0_dir;
    assign bus_fp.req1_valid = bus.req1_valid;
    assign bus_fp.req1_src   = bus.req1_src;
    assign bus_fp.req1_shamt = bus.req1_shamt;
    assign bus_fp.req1_dir   = bus.req1_dir;
    assign bus_fp.rsp_ready  = bus.rsp_ready;

    typedef struct {
        logic        id;
        logic [15:0] src;
        logic [3:0]  shamt;
        logic [1:0]  dir;
        logic [15:0] exp_data;
        logic        exp_zr;
    } vec_t;

    vec_t vecs[12];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic id, input logic [15:0] src, input logic [3:0] shamt,
                           input logic [1:0] dir);
        if (id == 1'b0) begin
            bus.req0_valid = 1'b1;
            bus.req0_src   = src;
            bus.req0_shamt = shamt;
            bus.req0_dir   = dir;
        end else begin
            bus.req1_valid = 1'b1;
            bus.req1_src   = src;
            bus.req1_shamt = shamt;
            bus.req1_dir   = dir;
        end
    endtask

    task automatic clear_req();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_op(input vec_t v, input int idx);
        set_req(v.id, v.src, v.shamt, v.dir);
        bus.rsp_ready = 1'b1;
        #1;
        check($sformatf("v%0d ready0", idx), 32'(bus.req0_ready), 32'(v.id == 1'b0));
        check($sformatf("v%0d ready1", idx), 32'(bus.req1_ready), 32'(v.id == 1'b1));
        tick();
        clear_req();
        check($sformatf("v%0d shift valid", idx), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("v%0d shift busy", idx), 32'(bus.busy), 32'd1);
        tick();
        check($sformatf("v%0d valid", idx), 32'(bus.rsp_valid), 32'd1);
        check($sformatf("v%0d data", idx), 32'(bus.rsp_data), 32'(v.exp_data));
        check($sformatf("v%0d zr", idx), 32'(bus.rsp_zr), 32'(v.exp_zr));
        check($sformatf("v%0d id", idx), 32'(bus.rsp_id), 32'(v.id));
        tick();
        check($sformatf("v%0d idle valid", idx), 32'(bus.rsp_valid), 32'd0);
        check($sformatf("v%0d idle busy", idx), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{1'b0, 16'h0001, 4'd4,  2'd1, 16'h0010, 1'b0};
        vecs[1]  = '{1'b1, 16'h8000, 4'd15, 2'd2, 16'h0001, 1'b0};
        vecs[2]  = '{1'b1, 16'h00F0, 4'd8,  2'd2, 16'h0000, 1'b1};
        vecs[3]  = '{1'b0, 16'hFFFF, 4'd1,  2'd0, 16'h7FFF, 1'b0};
        vecs[4]  = '{1'b0, 16'hFFFF, 4'd1,  2'd2, 16'h7FFF, 1'b0};
        vecs[5]  = '{1'b1, 16'hFFFF, 4'd1,  2'd3, 16'h7FFF, 1'b0};
        vecs[6]  = '{1'b0, 16'hFFFF, 4'd1,  2'd1, 16'hFFFE, 1'b0};
        vecs[7]  = '{1'b1, 16'hFFFF, 4'd0,  2'd1, 16'hFFFF, 1'b0};
        vecs[8]  = '{1'b0, 16'h1234, 4'd0,  2'd2, 16'h1234, 1'b0};
        vecs[9]  = '{1'b1, 16'h8001, 4'd15, 2'd1, 16'h8000, 1'b0};
        vecs[10] = '{1'b0, 16'hA5A5, 4'd4,  2'd1, 16'h5A50, 1'b0};
        vecs[11] = '{1'b1, 16'hA5A5, 4'd4,  2'd2, 16'h0A5A, 1'b0};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_src = '0; bus.req0_shamt = '0; bus.req0_dir = '0;
        bus.req1_valid = 1'b0; bus.req1_src = '0; bus.req1_shamt = '0; bus.req1_dir = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check("reset valid", 32'(bus.rsp_valid), 32'd0);
        check("reset data", 32'(bus.rsp_data), 32'd0);
        check("reset zr", 32'(bus.rsp_zr), 32'd0);
        check("reset id", 32'(bus.rsp_id), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset readys", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle no ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);

        for (int i = 0; i < 12; i++) do_op(vecs[i], i);

        // Continuous contention: round-robin alternates, fixed priority starves requester 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b0, 16'h0001, 4'd1, 2'd1);
        set_req(1'b1, 16'h0100, 4'd4, 2'd2);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr%0d ready0", k), 32'(bus.req0_ready), 32'(k % 2 == 0));
            check($sformatf("rr%0d ready1", k), 32'(bus.req1_ready), 32'(k % 2 == 1));
            check($sformatf("fp%0d readys", k), 32'({bus_fp.req1_ready, bus_fp.req0_ready}),
                  32'd1);
            tick();
            check($sformatf("rr%0d shift readys", k), 32'({bus.req1_ready, bus.req0_ready}),
                  32'd0);
            tick();
            check($sformatf("rr%0d valid", k), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("rr%0d id", k), 32'(bus.rsp_id), 32'(k % 2));
            check($sformatf("rr%0d data", k), 32'(bus.rsp_data),
                  (k % 2 == 0) ? 32'h0002 : 32'h0010);
            check($sformatf("fp%0d id", k), 32'(bus_fp.rsp_id), 32'd0);
            check($sformatf("rr%0d resp readys", k), 32'({bus.req1_ready, bus.req0_ready}),
                  32'd0);
            tick();
        end
        clear_req();
        tick();

        // Back-pressure: result held while rsp_ready is low.
        set_req(1'b0, 16'h00FF, 4'd4, 2'd1);
        bus.rsp_ready = 1'b0;
        #1;
        check("stall ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        clear_req();
        tick();
        set_req(1'b1, 16'h0F00, 4'd8, 2'd2);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall%0d valid", i), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("stall%0d data", i), 32'(bus.rsp_data), 32'h0FF0);
            check($sformatf("stall%0d id", i), 32'(bus.rsp_id), 32'd0);
            check($sformatf("stall%0d readys", i), 32'({bus.req1_ready, bus.req0_ready}),
                  32'd0);
            check($sformatf("stall%0d busy", i), 32'(bus.busy), 32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("release ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        #1;
        check("after rsp valid", 32'(bus.rsp_valid), 32'd0);
        check("after rsp ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        clear_req();
        tick();
        check("next op valid", 32'(bus.rsp_valid), 32'd1);
        check("next op data", 32'(bus.rsp_data), 32'h000F);
        check("next op id", 32'(bus.rsp_id), 32'd1);
        tick();

        // Reset during SHIFT discards the operation and restores the tie-break.
        set_req(1'b0, 16'h1234, 4'd2, 2'd1);
        #1;
        check("pre-rst ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        clear_req();
        check("pre-rst busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst valid", 32'(bus.rsp_valid), 32'd0);
        check("rst data", 32'(bus.rsp_data), 32'd0);
        check("rst id", 32'(bus.rsp_id), 32'd0);
        tick();
        check("no stale rsp", 32'(bus.rsp_valid), 32'd0);
        set_req(1'b0, 16'h0003, 4'd1, 2'd1);
        set_req(1'b1, 16'h0003, 4'd1, 2'd2);
        #1;
        check("post-rst ready0", 32'(bus.req0_ready), 32'd1);
        check("post-rst ready1", 32'(bus.req1_ready), 32'd0);
        tick();
        clear_req();
        tick();
        check("post-rst data", 32'(bus.rsp_data), 32'h0006);
        check("post-rst id", 32'(bus.rsp_id), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one 16-bit shifter instance between two requesters, for example the EX-stage ALU path and the address/immediate-generation path. Each requester uses a valid/ready request channel. The block arbitrates between them (round-robin or fixed priority), registers the granted operands, and drives the shifter from those registers. It returns the registered result, zero flag and requester ID on a single valid/ready response channel. Only one operation is in flight at a time.

Parameters:
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_src  input  16  requester 0 operand
req0_shamt  input  4  requester 0 shift amount, 0-15
req0_dir  input  2  requester 0 direction: 1 = shift left logical; 2, 0 or 3 = shift right logical
req1_valid, req1_ready, req1_src, req1_shamt, req1_dir  same directions, widths and meanings as the requester 0 ports, for requester 1
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes the result
rsp_data  output  16  shifted result
rsp_zr  output  1  1 when rsp_data == 16'h0000
rsp_id  output  1  requester that issued the operation
busy  output  1  high in SHIFT or RESP

Behaviour:
- Reset: rst high at a clock edge forces the following, regardless of current state:
  - state = IDLE
  - rsp_valid = 0, rsp_data = 0, rsp_zr = 0, rsp_id = 0, busy = 0
  - operand registers = 0
  - last_grant = 1, so requester 0 wins the first tie
- Reset mid-operation: the in-flight operation is discarded silently and no response is produced.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, and only for the granted requester.
  - Grant, only one valid: grant that requester.
  - Grant, both valid with RR_EN=1: grant the requester that is not last_grant.
  - Grant, both valid with RR_EN=0: grant requester 0.
  - Grant, neither valid: no ready asserted; stay in IDLE.
  - On handshake: capture src, shamt, dir and the granted ID; update last_grant; go to SHIFT.
  - At most one ready is high in any cycle.
- SHIFT:
  - The shifter inputs are driven only from the captured registers, never directly from the request ports.
  - At the end of the cycle, register shifter out into rsp_data and zr into rsp_zr, set rsp_valid = 1, go to RESP.
- RESP:
  - rsp_valid held high; rsp_data, rsp_zr and rsp_id held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid = 0 at the next edge; go to IDLE.
  - No request is accepted while in RESP.
- Timing:
  - Request handshake at edge N → rsp_valid high from edge N+2.
  - Minimum issue interval is 3 cycles: accept, shift, respond with rsp_ready already high.
- Requester obligations: hold valid and operands stable until ready. A requester dropping valid before ready is legal; the operation is simply not taken.
- Arithmetic: shift amount 0 returns src unchanged. Vacated bit positions are zero-filled; there is no arithmetic shift and no rotate. Directions 0 and 3 give the same result as direction 2.
- last_grant:
  - Updated on every accepted request, including uncontested ones.
  - A lone requester therefore loses the next tie.
  - With RR_EN=0 it is still tracked but ignored.

Test Plan:
- req0: src=16'h0001, shamt=4, dir=1, rsp_ready=1 → req0_ready in the same cycle; rsp_valid two edges later with rsp_data=16'h0010, rsp_zr=0, rsp_id=0; back in IDLE the cycle after.
- req1: src=16'h8000, shamt=15, dir=2 → rsp_data=16'h0001, rsp_id=1. Then req1: src=16'h00F0, shamt=8, dir=2 → rsp_data=16'h0000, rsp_zr=1.
- Both requesters valid continuously, RR_EN=1, rsp_ready=1 → grant order 0,1,0,1, one accept every 3 cycles. Repeat with RR_EN=0 → every grant goes to 0 and requester 1 starves.
- rsp_ready low for 5 cycles while in RESP → rsp_valid, rsp_data and rsp_id stable; both readys low; busy=1. rsp_ready high → handshake; the next accept no earlier than the following cycle.
- src=16'hFFFF, shamt=1, dir set in turn to 0, 2 and 3 → rsp_data=16'h7FFF for each. dir=1 → 16'hFFFE. shamt=0, dir=1 → 16'hFFFF.
- rst pulsed for one cycle while in SHIFT → next cycle state IDLE, rsp_valid=0, busy=0, no stale response. Both requesters then valid → requester 0 granted first.
